umi_tx_arbiter: RTL
===================

UMI_TX_ARBITER -- requirements
Module: umi_tx_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters, legal range 2..8.
REQ-002 Parameter DW, default 256, UMI packet width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 nreset  input  1  reset, asynchronous assert, active-low.
REQ-005 umi_valid_in  input  N  per-requester packet valid.
REQ-006 umi_packet_in  input  N*DW  requester i occupies bits [(i+1)*DW-1 : i*DW].
REQ-007 umi_ready_in  output  N  per-requester accept; at most one bit high per cycle.
REQ-008 umi_valid_out  output  1  shared TX port valid.
REQ-009 umi_packet_out  output  DW  shared TX port packet.
REQ-010 umi_ready_out  input  1  shared TX port accept.
REQ-011 umi_src_out  output  max(1,clog2(N))  index of the requester whose packet is on umi_packet_out.
REQ-012 umi_grant_cnt  output  N*16  per-requester accepted-packet counters; present only with UMI_ARB_STATS_EN.

Function
REQ-013 Handshake rule on every port: transfer occurs in a cycle where valid and ready are both high; the sender holds valid and packet stable until transfer.
REQ-014 The output stage is a single register slot with states EMPTY and FULL.
REQ-015 The slot is loadable in a cycle when state is EMPTY, or when state is FULL and umi_ready_out is high (drain and refill in the same cycle).
REQ-016 When the slot is loadable and any umi_valid_in bit is high, exactly one requester wins; its umi_ready_in bit is driven high combinationally that cycle; all other bits stay low.
REQ-017 Winner selection is round-robin: search starts at index (ptr+1) mod N and ascends with wrap; the first requester with valid high wins.
REQ-018 ptr updates to the winner index on each input transfer and holds otherwise.
REQ-019 On an input transfer, the winner's packet and index load into umi_packet_out/umi_src_out and state becomes FULL at the next edge; umi_valid_out rises one cycle after the input transfer (latency 1).
REQ-020 In FULL, umi_valid_out, umi_packet_out and umi_src_out hold stable until umi_ready_out is high.
REQ-021 FULL with umi_ready_out high and no valid input -> EMPTY, umi_valid_out low next cycle; umi_packet_out holds its last value.
REQ-022 FULL with umi_ready_out high and a valid input -> stays FULL with the new packet; sustained throughput is one packet per cycle.
REQ-023 umi_ready_in is low for all requesters when the slot is not loadable, regardless of umi_valid_in.
REQ-024 A requester that drops valid without a transfer is not granted and ptr is unchanged.

Reset
REQ-025 While nreset is low: state EMPTY, umi_valid_out 0, umi_packet_out 0, umi_src_out 0, umi_ready_in all 0, ptr N-1 (requester 0 has first priority), counters 0.
REQ-026 Reset asserted mid-transfer discards the held packet; no transfer completes in the reset cycle.
REQ-027 After nreset deasserts, the first grant may occur on the first clk edge.

Configuration
REQ-028 Macro UMI_ARB_STATS_EN defined: each requester has a 16-bit counter that increments by 1 on each of its input transfers, saturates at 0xFFFF and is driven on umi_grant_cnt.
REQ-029 Macro UMI_ARB_STATS_EN undefined: no counters and no umi_grant_cnt port; all other behaviour identical.

Verification
REQ-030 Single requester: N=4, only requester 2 valid with packet 0xA5.., umi_ready_out tied 1 -> umi_ready_in=4'b0100, next cycle umi_valid_out=1, umi_src_out=2, packet 0xA5...
REQ-031 All four valid continuously, umi_ready_out=1 -> grants 0,1,2,3,0,1... one per cycle, no gaps after first output.
REQ-032 Backpressure: umi_ready_out=0 for 5 cycles while FULL -> umi_packet_out/umi_src_out stable, umi_ready_in=0, ptr unchanged; on release, drain and refill in same cycle.
REQ-033 Requesters 1 and 3 valid, ptr=1 -> requester 3 wins; then requester 1 wins next loadable cycle.
REQ-034 nreset pulsed low while FULL with ready_out=0 -> umi_valid_out=0 asynchronously, next grant goes to requester 0.
REQ-035 UMI_ARB_STATS_EN defined: requester 0 sends 70000 packets -> its counter reads 0xFFFF, others 0.

Source files
------------

// File: rtl/umi_tx_arbiter.sv
// Round-robin arbiter: N UMI requesters share one registered TX slot (EMPTY/FULL).
// Define UMI_ARB_STATS_EN to add saturating per-requester grant counters on umi_grant_cnt.
module umi_tx_arbiter #(
    parameter int N  = 4,
    parameter int DW = 256,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    umi_valid_in,
    input  logic [N*DW-1:0] umi_packet_in,
    output logic [N-1:0]    umi_ready_in,
    output logic            umi_valid_out,
    output logic [DW-1:0]   umi_packet_out,
    input  logic            umi_ready_out,
    output logic [SW-1:0]   umi_src_out
`ifdef UMI_ARB_STATS_EN
    ,
    output logic [N*16-1:0] umi_grant_cnt
`endif
);

    // Valid/ready: a transfer happens on a posedge where valid and ready are both
    // high; the sender holds valid and data stable until then. umi_ready_in is
    // one-hot (or zero) and is driven combinationally from the slot state.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_pkt;
    logic [SW-1:0]   r_src;
    logic [SW-1:0]   r_ptr;

    logic            w_loadable;
    logic            w_found;
    logic            w_take;
    logic [SW-1:0]   w_win;
    logic [DW-1:0]   w_pkt;

    // Search ascends from the requester after the last winner, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && umi_valid_in[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_win   = SW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_loadable = (r_state == S_EMPTY) || umi_ready_out;
    // Gating with nreset keeps any grant from completing while reset is held.
    assign w_take     = nreset && w_loadable && w_found;
    assign w_pkt      = umi_packet_in[int'(w_win)*DW +: DW];

    assign umi_ready_in   = w_take ? (N'(1) << w_win) : '0;
    assign umi_valid_out  = (r_state == S_FULL);
    assign umi_packet_out = r_pkt;
    assign umi_src_out    = r_src;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_EMPTY;
            r_pkt   <= '0;
            r_src   <= '0;
            r_ptr   <= SW'(N - 1);
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_take) begin
                        r_state <= S_FULL;
                        r_pkt   <= w_pkt;
                        r_src   <= w_win;
                        r_ptr   <= w_win;
                    end
                end
                S_FULL: begin
                    // Drain and refill in the same cycle keeps one packet per clock.
                    if (w_take) begin
                        r_pkt   <= w_pkt;
                        r_src   <= w_win;
                        r_ptr   <= w_win;
                    end else if (umi_ready_out) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef UMI_ARB_STATS_EN
    logic [15:0] r_cnt [N];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else if (w_take && (r_cnt[w_win] != 16'hFFFF)) begin
            r_cnt[w_win] <= r_cnt[w_win] + 16'd1;
        end
    end

    always_comb begin
        umi_grant_cnt = '0;
        for (int i = 0; i < N; i++) umi_grant_cnt[i*16 +: 16] = r_cnt[i];
    end
`endif

endmodule
